// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit arbiter.
// Holds the FSM state encoding, the default destination port constants and
// the stream field widths.
package udp_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned USER_W = 32;
  localparam int unsigned KEEP_W = 8;
  localparam int unsigned PORT_W = 16;
  localparam int unsigned CNT_W  = 32;

  localparam logic [PORT_W-1:0] DST_PORT_0_DEF = 16'h0808;
  localparam logic [PORT_W-1:0] DST_PORT_1_DEF = 16'h0809;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_t;

endpackage

// File: rtl/udp_tx_arbiter.sv
// Two-source round-robin packet arbiter in front of the UDP transmit path.
// A granted packet first gets one CFG cycle that strobes its destination port,
// then its beats are forwarded combinationally until the last beat.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   s0_axis_user_*            source 0 stream (data/user/keep/last/valid, ready out)
//   s1_axis_user_*            source 1 stream (data/user/keep/last/valid, ready out)
//   m_axis_user_*             stream to the UDP transmit path (ready in)
//   o_dymanic_dst_port/valid  destination port of the granted packet + 1-cycle strobe
//   o_grant                   index of the granted source
//   o_busy                    high while in CFG or XFER
//   o_pkt_cnt_0/1             per-source packet counters (only with UDP_ARB_PKT_CNT_EN)
//
// Build option: define UDP_ARB_PKT_CNT_EN to add the per-source packet counters.
module udp_tx_arbiter
  import udp_pkg::*;
#(
  parameter logic [PORT_W-1:0] P_DST_PORT_0 = DST_PORT_0_DEF,
  parameter logic [PORT_W-1:0] P_DST_PORT_1 = DST_PORT_1_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic [DATA_W-1:0] s0_axis_user_data,
  input  logic [USER_W-1:0] s0_axis_user_user,
  input  logic [KEEP_W-1:0] s0_axis_user_keep,
  input  logic              s0_axis_user_last,
  input  logic              s0_axis_user_valid,
  output logic              s0_axis_user_ready,

  input  logic [DATA_W-1:0] s1_axis_user_data,
  input  logic [USER_W-1:0] s1_axis_user_user,
  input  logic [KEEP_W-1:0] s1_axis_user_keep,
  input  logic              s1_axis_user_last,
  input  logic              s1_axis_user_valid,
  output logic              s1_axis_user_ready,

  output logic [DATA_W-1:0] m_axis_user_data,
  output logic [USER_W-1:0] m_axis_user_user,
  output logic [KEEP_W-1:0] m_axis_user_keep,
  output logic              m_axis_user_last,
  output logic              m_axis_user_valid,
  input  logic              m_axis_user_ready,

  output logic [PORT_W-1:0] o_dymanic_dst_port,
  output logic              o_dymanic_dst_valid,
  output logic              o_grant,
  output logic              o_busy
`ifdef UDP_ARB_PKT_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_pkt_cnt_0,
  output logic [CNT_W-1:0]  o_pkt_cnt_1
`endif
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_prio;
  logic              r_grant;
  logic              r_busy;
  logic [PORT_W-1:0] r_dst_port;
  logic              r_dst_valid;

  logic              w_req_any;
  logic              w_pick;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic              w_beat_last;

  // Round-robin pick: priority only matters when both sources request.
  assign w_req_any = s0_axis_user_valid | s1_axis_user_valid;
  assign w_pick    = (s0_axis_user_valid & s1_axis_user_valid) ? r_prio : s1_axis_user_valid;

  // Handshake view of the granted source, used to detect the closing beat.
  assign w_sel_valid = r_grant ? s1_axis_user_valid : s0_axis_user_valid;
  assign w_sel_last  = r_grant ? s1_axis_user_last  : s0_axis_user_last;
  assign w_beat_last = (r_state == ST_XFER) & w_sel_valid & m_axis_user_ready & w_sel_last;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and the combinational stream mux.
  always_comb begin
    w_state_nxt        = r_state;
    m_axis_user_data   = '0;
    m_axis_user_user   = '0;
    m_axis_user_keep   = '0;
    m_axis_user_last   = 1'b0;
    m_axis_user_valid  = 1'b0;
    s0_axis_user_ready = 1'b0;
    s1_axis_user_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_any) w_state_nxt = ST_CFG;
      end
      ST_CFG: begin
        w_state_nxt = ST_XFER;
      end
      ST_XFER: begin
        if (r_grant) begin
          m_axis_user_data   = s1_axis_user_data;
          m_axis_user_user   = s1_axis_user_user;
          m_axis_user_keep   = s1_axis_user_keep;
          m_axis_user_last   = s1_axis_user_last;
          m_axis_user_valid  = s1_axis_user_valid;
          s1_axis_user_ready = m_axis_user_ready;
        end else begin
          m_axis_user_data   = s0_axis_user_data;
          m_axis_user_user   = s0_axis_user_user;
          m_axis_user_keep   = s0_axis_user_keep;
          m_axis_user_last   = s0_axis_user_last;
          m_axis_user_valid  = s0_axis_user_valid;
          s0_axis_user_ready = m_axis_user_ready;
        end
        if (w_beat_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant, priority, busy and the destination-port strobe.
  // The port is loaded at grant time so it is already valid during CFG.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio      <= 1'b0;
      r_grant     <= 1'b0;
      r_busy      <= 1'b0;
      r_dst_port  <= P_DST_PORT_0;
      r_dst_valid <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_dst_valid <= 1'b0;
      if ((r_state == ST_IDLE) && w_req_any) begin
        r_grant     <= w_pick;
        r_dst_port  <= w_pick ? P_DST_PORT_1 : P_DST_PORT_0;
        r_dst_valid <= 1'b1;
      end
      if (w_beat_last) r_prio <= ~r_grant;
    end
  end

  assign o_grant             = r_grant;
  assign o_busy              = r_busy;
  assign o_dymanic_dst_port  = r_dst_port;
  assign o_dymanic_dst_valid = r_dst_valid;

`ifdef UDP_ARB_PKT_CNT_EN
  logic [CNT_W-1:0] r_pkt_cnt_0;
  logic [CNT_W-1:0] r_pkt_cnt_1;

  // Completed packets per source; wraps naturally at the counter width.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pkt_cnt_0 <= '0;
      r_pkt_cnt_1 <= '0;
    end else if (w_beat_last) begin
      if (r_grant) r_pkt_cnt_1 <= r_pkt_cnt_1 + CNT_W'(1);
      else         r_pkt_cnt_0 <= r_pkt_cnt_0 + CNT_W'(1);
    end
  end

  assign o_pkt_cnt_0 = r_pkt_cnt_0;
  assign o_pkt_cnt_1 = r_pkt_cnt_1;
`endif

endmodule
